note_arbiter: RTL
=================

NOTE_ARBITER -- requirements
Module: note_arbiter

Interface
REQ-001 Parameter MIN_HOLD, default 100: minimum cycles a sequencer note plays before live preemption (10 ms at 10 kHz).
REQ-002 Parameter GAP, default 10: silent cycles inserted on every source release or switch (anti-click).
REQ-003 clk  input  1  10 kHz system clock; single clock domain.
REQ-004 n_rst  input  1  reset, synchronous and active-low.
REQ-005 live_note  input  4  note from live keypad encoder; 0 = no key.
REQ-006 seq_note  input  4  note_sustain from sequencer; 0 = rest.
REQ-007 seq_on  input  1  sequencer enabled flag.
REQ-008 note_out  output  4  note to oscillator; 0 = silence.
REQ-009 grant_live  output  1  high while live source owns note_out.
REQ-010 grant_seq  output  1  high while sequencer owns note_out.
REQ-011 preempt  output  1  one-cycle pulse when live preempts a sequencer note.

Function
REQ-012 States: IDLE, LIVE, SEQ, GAP; all outputs registered; latency input-to-note_out = 1 clk.
REQ-013 IDLE: note_out=0, grants 0; live_note!=0 -> LIVE (live wins simultaneous requests); else seq_on && seq_note!=0 -> SEQ.
REQ-014 Entering LIVE/SEQ: note_out loads that source's note; the grant goes high on the same edge; the shared timer clears.
REQ-015 LIVE: live_note changes to another nonzero value -> note_out updates next edge, no gap (legato); live_note==0 -> GAP.
REQ-016 SEQ: the timer counts up and saturates at MIN_HOLD; seq_note changes to another nonzero value -> note_out updates and the timer clears.
REQ-017 SEQ exit conditions are evaluated in priority order:
- seq_on==0 or seq_note==0 -> GAP.
- live_note!=0 and timer==MIN_HOLD -> GAP, preempt=1 for that cycle.
- live_note!=0 and timer<MIN_HOLD -> stay in SEQ; the live request waits.
REQ-018 GAP: note_out=0, grants 0, timer counts GAP cycles, then -> IDLE; inputs are ignored during GAP.
REQ-019 Grants are mutually exclusive; note_out!=0 only while exactly one grant is high.
REQ-020 Timer width = clog2(max(MIN_HOLD,GAP)+1); no wrap; saturating.
REQ-021 GAP=0 means GAP is transited in one cycle (IDLE on the next edge); MIN_HOLD=0 means immediate preemption.
REQ-022 seq_note arriving with seq_on==0 is ignored.

Reset
REQ-023 n_rst low at any clk edge, including mid-note or mid-GAP:
- state=IDLE, note_out=0, grant_live=0, grant_seq=0, preempt=0, timer=0.
REQ-024 First arbitration decision is made on the first edge after n_rst is sampled high.

Structure
REQ-025 The shared synth package holds:
- state enum arb_state_t {IDLE, LIVE, SEQ, GAP}.
- NOTE_W=4 constant, used for live_note, seq_note and note_out.
REQ-026 One sub-module, arb_timer: clear, enable, saturate-at-limit counter with a done flag; it is shared between the hold and gap functions because only one is active at a time.
REQ-027 The next-state/output logic is a single FSM in note_arbiter; no latches; no combinational path from inputs to outputs.

Verification (bench uses MIN_HOLD=4, GAP=2)
REQ-028 Reset mid-note:
- stimulus: live_note=5 held, n_rst low for 1 edge.
- response: note_out=0, grants 0 next edge; note_out=5 one edge after n_rst high.
REQ-029 Simultaneous requests:
- stimulus: live_note=3, seq_on=1, seq_note=7 in IDLE.
- response: grant_live=1, note_out=3; grant_seq never asserts.
REQ-030 Preemption after hold:
- stimulus: SEQ playing 7; live_note=2 asserted at hold cycle 1.
- response: note_out stays 7 until the timer reaches 4; preempt pulses 1 cycle; note_out=0 for 2 cycles; then IDLE; then note_out=2 with grant_live.
REQ-031 Legato:
- stimulus: LIVE with 4; live_note changes to 9.
- response: note_out=9 next edge; no zero cycle; grant_live stays 1.
REQ-032 Sequencer off mid-note:
- stimulus: SEQ with 6; seq_on drops.
- response: GAP with note_out=0 for 2 cycles; IDLE; note_out stays 0 with seq_note=6 still present.
REQ-033 Rest then new note:
- stimulus: seq_note 8 -> 0 -> 8.
- response: GAP of 2 zero cycles; then re-grant to SEQ; the timer restarts from 0.

Source files
------------

// File: rtl/note_arbiter_pkg.sv
// Shared types and constants for the note arbiter.
package note_arbiter_pkg;

   localparam int NOTE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LIVE = 2'd1,
      SEQ  = 2'd2,
      GAP  = 2'd3
   } arb_state_t;

   // Width needed to hold the larger of the two timer limits (never zero).
   function automatic int timer_width(input int hold, input int gap);
      int m;
      m = (hold > gap) ? hold : gap;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/note_arbiter_timer.sv
// Clear/enable counter that stops at a programmable limit; shared by hold and gap timing.
module arb_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic [W-1:0] count_o,
   output logic         done_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Clear wins over enable; counting stops once the limit is reached.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q < limit_i)) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign done_o  = (count_q >= limit_i);

endmodule

// File: rtl/note_arbiter.sv
// Arbitrates the live keypad and the sequencer onto one oscillator note,
// with a minimum sequencer hold before live preemption and a silent gap
// on every release or source switch.
module note_arbiter
   import note_arbiter_pkg::*;
#(
   parameter int MIN_HOLD = 100,
   parameter int GAP      = 10
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [NOTE_W-1:0] live_note,
   input  logic [NOTE_W-1:0] seq_note,
   input  logic              seq_on,
   output logic [NOTE_W-1:0] note_out,
   output logic              grant_live,
   output logic              grant_seq,
   output logic              preempt
);

   localparam int TW = timer_width(MIN_HOLD, GAP);
   localparam logic [TW-1:0] HOLD_LIM = TW'(MIN_HOLD);
   // The gap state is counted from zero, so the limit is one less than the
   // number of silent cycles; GAP=0 still spends a single cycle there.
   localparam logic [TW-1:0] GAP_LIM  = (GAP == 0) ? '0 : TW'(GAP - 1);
   // The GAP parameter shadows the enum literal, so name the state explicitly.
   localparam arb_state_t S_GAP = note_arbiter_pkg::GAP;

   arb_state_t        state_q, state_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic              grant_live_q, grant_live_d;
   logic              grant_seq_q, grant_seq_d;
   logic              preempt_q, preempt_d;

   logic              tmr_clr, tmr_en, tmr_done;
   logic [TW-1:0]     tmr_limit, tmr_count;

   assign tmr_limit = (state_q == S_GAP) ? GAP_LIM : HOLD_LIM;

   arb_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .n_rst   (n_rst),
      .clr_i   (tmr_clr),
      .en_i    (tmr_en),
      .limit_i (tmr_limit),
      .count_o (tmr_count),
      .done_o  (tmr_done)
   );

   // Next-state, next-output and timer control.
   always_comb begin
      state_d      = state_q;
      note_d       = note_q;
      grant_live_d = grant_live_q;
      grant_seq_d  = grant_seq_q;
      preempt_d    = 1'b0;
      tmr_clr      = 1'b0;
      tmr_en       = 1'b0;
      case (state_q)
         IDLE: begin
            tmr_clr      = 1'b1;
            note_d       = '0;
            grant_live_d = 1'b0;
            grant_seq_d  = 1'b0;
            if (live_note != '0) begin
               state_d      = LIVE;
               note_d       = live_note;
               grant_live_d = 1'b1;
            end else if (seq_on && (seq_note != '0)) begin
               state_d     = SEQ;
               note_d      = seq_note;
               grant_seq_d = 1'b1;
            end
         end
         LIVE: begin
            if (live_note == '0) begin
               state_d      = S_GAP;
               note_d       = '0;
               grant_live_d = 1'b0;
               tmr_clr      = 1'b1;
            end else begin
               note_d = live_note;
            end
         end
         SEQ: begin
            tmr_en = 1'b1;
            if (!seq_on || (seq_note == '0)) begin
               state_d     = S_GAP;
               note_d      = '0;
               grant_seq_d = 1'b0;
               tmr_clr     = 1'b1;
            end else if ((live_note != '0) && tmr_done) begin
               state_d     = S_GAP;
               note_d      = '0;
               grant_seq_d = 1'b0;
               preempt_d   = 1'b1;
               tmr_clr     = 1'b1;
            end else if (seq_note != note_q) begin
               note_d  = seq_note;
               tmr_clr = 1'b1;
            end
         end
         default: begin
            note_d       = '0;
            grant_live_d = 1'b0;
            grant_seq_d  = 1'b0;
            if (tmr_done) begin
               state_d = IDLE;
            end else begin
               tmr_en = 1'b1;
            end
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         note_q       <= '0;
         grant_live_q <= 1'b0;
         grant_seq_q  <= 1'b0;
         preempt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         note_q       <= note_d;
         grant_live_q <= grant_live_d;
         grant_seq_q  <= grant_seq_d;
         preempt_q    <= preempt_d;
      end
   end

   assign note_out   = note_q;
   assign grant_live = grant_live_q;
   assign grant_seq  = grant_seq_q;
   assign preempt    = preempt_q;

endmodule
